// File: rtl/fps_seg_display.sv
// Six-digit common-anode seven-segment driver for the fps counter.
// Binary-to-BCD conversion uses a sequential shift-add-3 engine, followed by leading-zero blanking and digit scanning.
`timescale 1ns/1ps

module fps_seg_display #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIGIT_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] data,
    input  logic        en,
    output logic [5:0]  seg_sel,
    output logic [7:0]  seg_led,
    output logic        busy
);

    localparam int DIV   = CLK_FREQ / DIGIT_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [19:0]        snap;
    logic [19:0]        shift_bin;
    logic [23:0]        bcd;
    logic [23:0]        bcd_adj;
    logic [23:0]        disp_bcd;
    logic [4:0]         bit_cnt;
    logic [DIV_W-1:0]   div;
    logic [2:0]         idx;
    logic [2:0]         msd;
    logic [3:0]         cur_nib;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (data != snap) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 5'd19) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction is applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            shift_bin <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            disp_bcd  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (data != snap) begin
                        shift_bin <= (data > 20'd999999) ? 20'd999999 : data;
                        snap      <= data;
                        bcd       <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, shift_bin} <= {bcd_adj[22:0], shift_bin, 1'b0};
                    bit_cnt          <= bit_cnt + 5'd1;
                end
                DONE:    disp_bcd <= bcd;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(DIV - 1)) begin
            div <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // msd stays 0 for an all-zero value so the units digit always shows.
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) msd = 3'(i);
        end
    end

    always_comb begin
        cur_nib = disp_bcd[3:0];
        case (idx)
            3'd1:    cur_nib = disp_bcd[7:4];
            3'd2:    cur_nib = disp_bcd[11:8];
            3'd3:    cur_nib = disp_bcd[15:12];
            3'd4:    cur_nib = disp_bcd[19:16];
            3'd5:    cur_nib = disp_bcd[23:20];
            default: cur_nib = disp_bcd[3:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel <= 6'b111111;
            seg_led <= 8'hFF;
        end else begin
            seg_sel <= en ? ~(6'b000001 << idx) : 6'b111111;
            seg_led <= (idx > msd) ? 8'hFF : seg_code(cur_nib);
        end
    end

endmodule

// File: tb/tb_fps_seg_display.sv
// Directed bench for fps_seg_display: a table of values with hand-computed digit codes,
// plus sequences for conversion latency, data changes during conversion, enable and reset.
`timescale 1ns/1ps

module tb_fps_seg_display;

    localparam int DIV = 8;

    logic        clk;
    logic        rst_n;
    logic [19:0] data;
    logic        en;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [19:0]     data;
        logic [5:0][7:0] segs;
    } vec_t;

    vec_t vecs[10];

    fps_seg_display #(
        .CLK_FREQ (DIV),
        .DIGIT_HZ (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .en      (en),
        .seg_sel (seg_sel),
        .seg_led (seg_led),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sel_index(input logic [5:0] s);
        for (int k = 0; k < 6; k++) begin
            if (s == 6'(~(6'b000001 << k))) return k;
        end
        return -1;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: busy still high after %0d cycles", name, n);
        end
    endtask

    // Scan one full frame and compare every digit the first time it is selected.
    task automatic check_frame(input string tag, input logic [5:0][7:0] exp);
        bit seen[6];
        int k;
        for (int i = 0; i < 6; i++) seen[i] = 1'b0;
        for (int c = 0; c < 7 * DIV; c++) begin
            step();
            k = sel_index(seg_sel);
            if (k >= 0 && !seen[k]) begin
                seen[k] = 1'b1;
                check($sformatf("%s digit%0d", tag, k), 32'(seg_led), 32'(exp[k]));
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (!seen[i]) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL %s digit%0d: never selected, expected %0h", tag, i, exp[i]);
            end
        end
    endtask

    task automatic apply_value(input string tag, input logic [19:0] v, input logic [5:0][7:0] exp);
        data = v;
        repeat (2) step();
        wait_idle(tag);
        repeat (3) step();
        check_frame(tag, exp);
    endtask

    initial begin
        int cnt;
        int k0;
        int c;
        int k;
        bit saw_busy;
        bit changed;
        logic [5:0] prev;
        logic [5:0][7:0] exp123;

        vecs[0] = '{20'd0,       {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[1] = '{20'd7,       {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8}};
        vecs[2] = '{20'd60,      {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h82, 8'hC0}};
        vecs[3] = '{20'd1048575, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[4] = '{20'd999999,  {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[5] = '{20'd1000000, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[6] = '{20'd100000,  {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[7] = '{20'd456789,  {8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90}};
        vecs[8] = '{20'd123,     {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0}};
        vecs[9] = '{20'd1000,    {8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0}};
        exp123  = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0};

        rst_n = 1'b0;
        en    = 1'b1;
        data  = 20'd0;
        repeat (3) step();
        check("reset seg_sel", 32'(seg_sel), 32'h3F);
        check("reset seg_led", 32'(seg_led), 32'hFF);
        check("reset busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Zero after reset matches snap, so no conversion may start.
        saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy) saw_busy = 1'b1;
        end
        check("zero no conversion", 32'(saw_busy), 32'h0);
        check_frame("zero", vecs[0].segs);

        data = 20'd60;
        cnt = 0;
        step();
        while (busy && cnt < 60) begin
            cnt++;
            step();
        end
        check("busy cycles for 60", 32'(cnt), 32'd21);
        repeat (3) step();
        check_frame("sixty", vecs[2].segs);

        for (int i = 0; i < 10; i++) begin
            apply_value($sformatf("vec%0d", i), vecs[i].data, vecs[i].segs);
        end

        // Data changes mid-conversion: 123 must land first, then 456789 re-triggers.
        data = 20'd123;
        step();
        check("busy after load", 32'(busy), 32'h1);
        repeat (5) step();
        data = 20'd456789;
        wait_idle("first conversion");
        check("idle gap busy low", 32'(busy), 32'h0);
        step();
        check("retrigger busy", 32'(busy), 32'h1);
        for (int i = 0; i < 10; i++) begin
            k = sel_index(seg_sel);
            if (k < 0) k = 0;
            check($sformatf("interim 123 digit%0d", k), 32'(seg_led), 32'(exp123[k]));
            step();
        end
        wait_idle("second conversion");
        repeat (3) step();
        check_frame("final 456789", vecs[7].segs);

        // Locate a digit boundary so the scan position can be predicted across en toggling.
        prev = seg_sel;
        changed = 1'b0;
        for (int i = 0; i < 3 * DIV && !changed; i++) begin
            step();
            if (seg_sel != prev) changed = 1'b1;
        end
        check("scan boundary found", 32'(changed), 32'h1);
        k0 = sel_index(seg_sel);
        if (k0 < 0) k0 = 0;
        c = 0;
        repeat (3) step();
        c += 3;
        en = 1'b0;
        step();
        c++;
        check("en low blanks select", 32'(seg_sel), 32'h3F);
        repeat (16) step();
        c += 16;
        check("en low still blank", 32'(seg_sel), 32'h3F);
        en = 1'b1;
        step();
        c++;
        check("en resume digit", 32'(seg_sel), 32'(6'(~(6'b000001 << ((k0 + c / DIV) % 6)))));
        repeat (3) step();
        c += 3;
        check("en resume next digit", 32'(seg_sel), 32'(6'(~(6'b000001 << ((k0 + c / DIV) % 6)))));

        // Reset in the middle of a conversion clears outputs at once and forces a reconversion.
        data = 20'd777;
        step();
        check("777 busy", 32'(busy), 32'h1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("async reset seg_sel", 32'(seg_sel), 32'h3F);
        check("async reset seg_led", 32'(seg_led), 32'hFF);
        check("async reset busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        wait_idle("777 reconvert");
        repeat (3) step();
        check_frame("777", {8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hF8, 8'hF8});

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fps_seg_display.md
# fps_seg_display

Six-digit common-anode seven-segment driver that consumes the 20-bit binary frame-rate count produced once per second by the fps counter. It converts the binary value to BCD with a sequential shift-add-3 engine, applies leading-zero blanking, and time-multiplexes the six digits. It sits between the fps counter and the board's segment/select pins.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- DIGIT_HZ, 1000: per-digit refresh rate; a full six-digit frame takes 6/DIGIT_HZ s.
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- data  input  20  unsigned binary value to display; may change on any cycle.
- en  input  1  display enable; 0 blanks all digits. Conversion and scanning continue.
- seg_sel  output  6  digit select, active-low; bit 0 is the units digit (rightmost).
- seg_led  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp is always 1 (off).
- busy  output  1  high while a BCD conversion is in progress.

## Operation
- Conversion FSM with states IDLE, SHIFT, DONE.
  - IDLE: if data != snap, the FSM loads shift_bin <= min(data, 999999), snap <= data, clears the 24-bit BCD accumulator, sets bit_cnt=0, and goes to SHIFT. Otherwise it stays in IDLE.
  - SHIFT: each cycle, any BCD nibble >= 5 first has 3 added to it; then {bcd, shift_bin} shifts left by 1. bit_cnt increments. After the 20th shift the FSM goes to DONE.
  - DONE: disp_bcd <= bcd (all six nibbles in one atomic write); next state is IDLE.
- snap resets to 0 and disp_bcd resets to 0. A data value of 0 after reset therefore triggers no conversion, and the display shows "0".
- Saturation: any data > 999999 (up to 1048575) displays as 999999. snap still holds the raw data value.
- data changes during SHIFT/DONE are ignored. On return to IDLE the compare against snap re-triggers a conversion, so the final stable value is always displayed.
- busy = (state != IDLE).
- Scan:
  - Divider counts 0..CLK_FREQ/DIGIT_HZ-1. On wrap, digit index idx advances 0→1→…→5→0.
  - seg_sel = ~(6'b1 << idx) when en=1; 6'b111111 when en=0.
- Blanking: let msd = the highest index with a nonzero nibble in disp_bcd (msd = 0 if all nibbles are zero). Digits with idx > msd output seg_led = 8'hFF. Digit 0 is never blanked.
- Segment codes for 0–9 (active-low, dp off): C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. Nibbles 10–15 cannot occur; map them to FF.

## Timing
- Reset values: seg_sel = 6'b111111, seg_led = 8'hFF, busy = 0, state = IDLE, idx = 0, divider = 0, disp_bcd = 0.
- seg_sel and seg_led are registered. They update together one cycle after an idx change or a disp_bcd change, so the select and segment outputs never mismatch.
- Conversion latency:
  - data differs from snap at edge T (IDLE): load.
  - Edges T+1..T+20: SHIFT.
  - Edge T+21: DONE writes disp_bcd.
  - seg_led reflects the new value at edge T+22 for the currently selected digit.
  - busy is high from T+1 through T+21.
- Consecutive conversions are separated by at least one IDLE cycle.
- en takes effect on seg_sel at the next clock edge. The divider and idx are unaffected by en.
- Asynchronous reset mid-conversion aborts it. disp_bcd returns to 0 and outputs return to their reset values immediately.

## Test plan
- Reset, then data=0, en=1 → no conversion (busy stays 0). Over one scan frame: idx=0 shows C0; idx 1–5 show FF.
- data=20'd60 → busy high for exactly 21 cycles. Then idx0=C0, idx1=82, idx2..5=FF.
- data=20'd1048575 → display 999999: all six digits show 90. data=20'd999999 gives the identical display.
- data changes 123→456789 while busy=1 → first conversion completes (display 123). A second conversion starts one cycle after DONE. Final display shows 456789: digits 0..5 = 90, 80, F8, 82, 92, 99.
- en toggled 1→0→1 mid-frame → seg_sel=6'b111111 one cycle after en falls. The scan index continues advancing, and output resumes on the correct digit.
- rst_n asserted during SHIFT of data=777 → seg_sel=6'b111111 and seg_led=FF immediately. After release, 777 is reconverted and displays F8 on digits 0–2, with digits 3–5 showing FF.
